// File: rtl/uart_word_rx_pkg.sv
// Shared definitions for the word-assembling UART receiver.
// Optional 8E1 framing is enabled by defining UART_PARITY_EN.
package uart_word_rx_pkg;

    // UART frame constants
    localparam int   DATA_BITS  = 8;
    localparam logic IDLE_LEVEL = 1'b1;

    // Receiver FSM states; PARITY is only entered when UART_PARITY_EN is defined
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_e;

endpackage

// File: rtl/uart_word_rx_bit_sampler.sv
// Serial front end: rxd synchroniser, start detection, mid-bit sampling
// and byte shift register. Emits one byte_valid or byte_err pulse per frame.
// With UART_PARITY_EN defined the frame is 8E1, otherwise 8N1.
module uart_bit_sampler
    import uart_word_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rxd_i,
    output logic       byte_valid_o,
    output logic [7:0] byte_data_o,
    output logic       byte_err_o,
    output logic       busy_o
);

    localparam int             CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]     BIT_LAST = 3'(DATA_BITS - 1);

    rx_state_e      state_q;
    logic           sync1_q;
    logic           rs_q;
    logic           rs_prev_q;
    logic [CW-1:0]  cnt_q;
    logic [2:0]     bit_q;
    logic [7:0]     shreg_q;
    logic           byte_valid_q;
    logic           byte_err_q;
`ifdef UART_PARITY_EN
    logic           par_err_q;
`endif

    // Two-flop synchroniser plus a delayed copy for falling-edge detection
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q   <= IDLE_LEVEL;
            rs_q      <= IDLE_LEVEL;
            rs_prev_q <= IDLE_LEVEL;
        end else begin
            sync1_q   <= rxd_i;
            rs_q      <= sync1_q;
            rs_prev_q <= rs_q;
        end
    end

    // Frame FSM; only a 1->0 edge starts a frame, so a held-low break cannot retrigger
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            shreg_q      <= '0;
            byte_valid_q <= 1'b0;
            byte_err_q   <= 1'b0;
`ifdef UART_PARITY_EN
            par_err_q    <= 1'b0;
`endif
        end else begin
            byte_valid_q <= 1'b0;
            byte_err_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (rs_prev_q && !rs_q) state_q <= ST_START;
                end
                ST_START: begin
                    if (cnt_q == CNT_HALF) begin
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        state_q <= rs_q ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        shreg_q <= {rs_q, shreg_q[7:1]};
                        bit_q   <= bit_q + 1'b1;
                        if (bit_q == BIT_LAST) begin
`ifdef UART_PARITY_EN
                            state_q <= ST_PARITY;
`else
                            state_q <= ST_STOP;
`endif
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
`ifdef UART_PARITY_EN
                ST_PARITY: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q     <= '0;
                        par_err_q <= ^{shreg_q, rs_q};
                        state_q   <= ST_STOP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
`ifdef UART_PARITY_EN
                        if (rs_q && !par_err_q) byte_valid_q <= 1'b1;
                        else                    byte_err_q   <= 1'b1;
`else
                        if (rs_q) byte_valid_q <= 1'b1;
                        else      byte_err_q   <= 1'b1;
`endif
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign byte_valid_o = byte_valid_q;
    assign byte_err_o   = byte_err_q;
    assign byte_data_o  = shreg_q;
    assign busy_o       = (state_q != ST_IDLE);

endmodule

// File: rtl/uart_word_rx.sv
// UART receiver assembling WORD_BYTES bytes (first byte in [7:0]) into a word
// with valid/ready output, overrun detection and inter-byte idle timeout.
// Define UART_PARITY_EN for 8E1 framing with even-parity checking.
module uart_word_rx
    import uart_word_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int WORD_BYTES   = 4,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            rxd_i,
    output logic [8*WORD_BYTES-1:0]         word_data_o,
    output logic                            word_valid_o,
    input  logic                            word_ready_i,
    output logic [$clog2(WORD_BYTES+1)-1:0] byte_count_o,
    output logic                            frame_err_o,
    output logic                            overrun_o,
    output logic                            timeout_o,
    output logic                            busy_o
);

    localparam int              W         = 8 * WORD_BYTES;
    localparam int              BCW       = $clog2(WORD_BYTES + 1);
    localparam int              TLIM      = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int              TCW       = $clog2(TLIM);
    localparam logic [BCW-1:0]  LAST_BYTE = BCW'(WORD_BYTES - 1);
    localparam logic [TCW-1:0]  TMO_LAST  = TCW'(TLIM - 1);

    logic           byte_valid;
    logic [7:0]     byte_data;
    logic           byte_err;
    logic           samp_busy;

    logic [W-1:0]   acc_q, acc_d;
    logic [W-1:0]   word_q, word_d;
    logic           valid_q, valid_d;
    logic [BCW-1:0] bc_q, bc_d;
    logic [TCW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic           ferr_q, ferr_d;
    logic           ovr_q, ovr_d;
    logic           tmo_q, tmo_d;
    logic           accept;

    uart_bit_sampler #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_sampler (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .rxd_i        (rxd_i),
        .byte_valid_o (byte_valid),
        .byte_data_o  (byte_data),
        .byte_err_o   (byte_err),
        .busy_o       (samp_busy)
    );

    assign accept = valid_q && word_ready_i;

    // Byte assembly, output handshake and idle timeout next-state
    always_comb begin
        acc_d     = acc_q;
        word_d    = word_q;
        valid_d   = valid_q;
        bc_d      = bc_q;
        tmo_cnt_d = '0;
        ferr_d    = 1'b0;
        ovr_d     = 1'b0;
        tmo_d     = 1'b0;

        if (accept) valid_d = 1'b0;

        if (byte_err) begin
            ferr_d = 1'b1;
            bc_d   = '0;
        end else if (byte_valid) begin
            acc_d[8*int'(bc_q) +: 8] = byte_data;
            if (bc_q == LAST_BYTE) begin
                bc_d = '0;
                // A word completing while the previous one is still held is dropped
                if (!valid_q || accept) begin
                    word_d  = acc_d;
                    valid_d = 1'b1;
                end else begin
                    ovr_d = 1'b1;
                end
            end else begin
                bc_d = bc_q + 1'b1;
            end
        end else if (bc_q != '0 && !samp_busy) begin
            if (tmo_cnt_q == TMO_LAST) begin
                tmo_d = 1'b1;
                bc_d  = '0;
            end else begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
        end
    end

    // Output and assembly state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q     <= '0;
            word_q    <= '0;
            valid_q   <= 1'b0;
            bc_q      <= '0;
            tmo_cnt_q <= '0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            word_q    <= word_d;
            valid_q   <= valid_d;
            bc_q      <= bc_d;
            tmo_cnt_q <= tmo_cnt_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
            tmo_q     <= tmo_d;
        end
    end

    assign word_data_o  = word_q;
    assign word_valid_o = valid_q;
    assign byte_count_o = bc_q;
    assign frame_err_o  = ferr_q;
    assign overrun_o    = ovr_q;
    assign timeout_o    = tmo_q;
    assign busy_o       = samp_busy;

endmodule

// File: tb/tb_uart_word_rx.sv
// Scoreboard bench for uart_word_rx: stimulus pushes expected words/pulses,
// a monitor process pops and compares whenever the DUT presents one.
module tb_uart_word_rx;

    localparam int CPB = 8;
    localparam int WB  = 4;
    localparam int TOB = 20;

    localparam int K_WORD = 0;
    localparam int K_FERR = 1;
    localparam int K_OVR  = 2;
    localparam int K_TMO  = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rxd = 1'b1;
    logic        word_ready = 1'b1;
    logic [31:0] word_data;
    logic        word_valid;
    logic [2:0]  byte_count;
    logic        frame_err;
    logic        overrun;
    logic        timeout;
    logic        busy;

    always #5 clk = ~clk;

    uart_word_rx #(
        .CLKS_PER_BIT (CPB),
        .WORD_BYTES   (WB),
        .TIMEOUT_BITS (TOB)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .rxd_i        (rxd),
        .word_data_o  (word_data),
        .word_valid_o (word_valid),
        .word_ready_i (word_ready),
        .byte_count_o (byte_count),
        .frame_err_o  (frame_err),
        .overrun_o    (overrun),
        .timeout_o    (timeout),
        .busy_o       (busy)
    );

    typedef struct {
        int          kind;
        logic [31:0] data;
    } exp_t;

    exp_t       sbq[$];
    int         n_cmp = 0;
    int         n_err = 0;
    logic       log_en = 1'b0;
    logic [2:0] bc_log[$];
    int         vld_cycles = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic expect_ev(input int k, input logic [31:0] d);
        exp_t e;
        e.kind = k;
        e.data = d;
        sbq.push_back(e);
    endtask

    task automatic pop_cmp(input int k, input logic [31:0] d);
        exp_t e;
        n_cmp++;
        if (sbq.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard: got kind=%0d data=%0h, nothing expected", k, d);
        end else begin
            e = sbq.pop_front();
            if (e.kind != k || e.data !== d) begin
                n_err++;
                $display("FAIL scoreboard: got kind=%0d data=%0h expected kind=%0d data=%0h",
                         k, d, e.kind, e.data);
            end
        end
    endtask

    task automatic monitor();
        logic [2:0] prev_bc;
        prev_bc = 3'd0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (word_valid && word_ready) pop_cmp(K_WORD, word_data);
                if (frame_err) pop_cmp(K_FERR, 32'd0);
                if (overrun)   pop_cmp(K_OVR, 32'd0);
                if (timeout)   pop_cmp(K_TMO, 32'd0);
                if (log_en && byte_count != prev_bc) bc_log.push_back(byte_count);
                if (log_en && word_valid) vld_cycles++;
            end
            prev_bc = byte_count;
        end
    endtask

    task automatic bit_time(input logic v);
        rxd = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_lvl, input logic bad_par);
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(b[i]);
`ifdef UART_PARITY_EN
        bit_time((^b) ^ bad_par);
`else
        if (bad_par) bit_time(1'b1);
`endif
        bit_time(stop_lvl);
        rxd = 1'b1;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1, 1'b0);
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] bc_exp[4];
        bc_exp = '{3'd1, 3'd2, 3'd3, 3'd0};
        fork
            monitor();
        join_none

        // Reset state
        wait_clks(3);
        chk("reset word_data", word_data, 32'd0);
        chk("reset word_valid", word_valid, 1'b0);
        chk("reset byte_count", byte_count, 3'd0);
        chk("reset frame_err", frame_err, 1'b0);
        chk("reset overrun", overrun, 1'b0);
        chk("reset timeout", timeout, 1'b0);
        chk("reset busy", busy, 1'b0);
        rst_n = 1'b1;
        wait_clks(3);

        // Back-to-back word 0x12345678
        expect_ev(K_WORD, 32'h12345678);
        log_en = 1'b1;
        send_word(32'h12345678);
        wait_clks(4);
        log_en = 1'b0;
        chk("bc sequence length", bc_log.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < bc_log.size()) chk("bc sequence entry", bc_log[i], bc_exp[i]);
        chk("word_valid cycles", vld_cycles, 1);

        // Glitch shorter than half a bit
        rxd = 1'b0;
        wait_clks(3);
        rxd = 1'b1;
        wait_clks(12);
        chk("glitch busy", busy, 1'b0);
        chk("glitch byte_count", byte_count, 3'd0);

        // Framing error then a clean word
        expect_ev(K_FERR, 32'd0);
        send_byte(8'h55, 1'b0, 1'b0);
        bit_time(1'b1);
        bit_time(1'b1);
        chk("ferr byte_count", byte_count, 3'd0);
        expect_ev(K_WORD, 32'hDEADBEEF);
        send_word(32'hDEADBEEF);
        wait_clks(4);

        // Overrun with consumer stalled
        word_ready = 1'b0;
        expect_ev(K_OVR, 32'd0);
        expect_ev(K_WORD, 32'h11111111);
        send_word(32'h11111111);
        send_word(32'h22222222);
        wait_clks(4);
        chk("overrun word_valid held", word_valid, 1'b1);
        chk("overrun word_data kept", word_data, 32'h11111111);
        chk("overrun byte_count", byte_count, 3'd0);
        word_ready = 1'b1;
        wait_clks(1);
        chk("valid drops after accept", word_valid, 1'b0);

        // Inter-byte timeout
        send_byte(8'hA1, 1'b1, 1'b0);
        send_byte(8'hB2, 1'b1, 1'b0);
        wait_clks(4);
        chk("partial byte_count", byte_count, 3'd2);
        expect_ev(K_TMO, 32'd0);
        wait_clks(TOB * CPB + 20);
        chk("timeout byte_count", byte_count, 3'd0);
        expect_ev(K_WORD, 32'h01020304);
        send_word(32'h01020304);
        wait_clks(4);

        // Reset in the DATA state of byte 3
        send_byte(8'h33, 1'b1, 1'b0);
        send_byte(8'h44, 1'b1, 1'b0);
        bit_time(1'b0);
        bit_time(1'b1);
        bit_time(1'b0);
        bit_time(1'b1);
        chk("busy before reset", busy, 1'b1);
        rst_n = 1'b0;
        rxd = 1'b1;
        wait_clks(2);
        chk("midreset word_data", word_data, 32'd0);
        chk("midreset word_valid", word_valid, 1'b0);
        chk("midreset byte_count", byte_count, 3'd0);
        chk("midreset busy", busy, 1'b0);
        rst_n = 1'b1;
        wait_clks(4);
        expect_ev(K_WORD, 32'h0D0C0B0A);
        send_word(32'h0D0C0B0A);
        wait_clks(4);

`ifdef UART_PARITY_EN
        // Wrong parity bit on 0x01
        expect_ev(K_FERR, 32'd0);
        send_byte(8'h01, 1'b1, 1'b1);
        bit_time(1'b1);
        chk("parity byte_count", byte_count, 3'd0);
`endif

        wait_clks(10);
        chk("scoreboard drained", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_word_rx.md
Name: uart_word_rx

Overview:
- Parametrised UART receiver that assembles WORD_BYTES serial bytes into one word, e.g. a 32-bit nonce or a header chunk from the host.
- Sits between the board rxd pin and the miner control logic.
- Generalises the current fixed 8-bit UART path with:
  - a configurable baud divider and word width;
  - a valid/ready output handshake;
  - framing, overrun and inter-byte timeout handling.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); must be >= 4.
- WORD_BYTES, 4, bytes per assembled word; range 1..32.
- TIMEOUT_BITS, 20, idle bit-periods allowed between bytes of one word before the partial word is discarded.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous reset, active-low (asserted when 0).
- rxd  in  1  asynchronous serial input, idle high, 8N1.
- word_data  out  8*WORD_BYTES  assembled word; first byte received occupies [7:0].
- word_valid  out  1  word_data holds an unconsumed word.
- word_ready  in  1  consumer accepts the word when word_valid && word_ready.
- byte_count  out  $clog2(WORD_BYTES+1)  bytes of the current partial word collected so far.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: completed word dropped because the output was full.
- timeout  out  1  one-cycle pulse: partial word discarded by the idle timer.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset values:
  - word_data=0, word_valid=0, byte_count=0.
  - All pulse outputs 0, busy=0.
  - Synchroniser flops=1, FSM=IDLE.
- rxd passes through a 2-FF synchroniser. Every sample below uses the synchronised value rs.
- FSM states: IDLE, START, DATA, STOP. A single bit counter runs from 0 to CLKS_PER_BIT-1.
- IDLE:
  - A 1->0 transition on rs goes to START with the counter cleared.
- START:
  - At count (CLKS_PER_BIT/2)-1, sample rs.
  - rs==0: go to DATA with the counter cleared.
  - rs==1: false start; return to IDLE with no output.
- DATA:
  - Sample rs at each count CLKS_PER_BIT-1, which is mid-bit.
  - Shift the sample into the byte register LSB-first.
  - After 8 samples, go to STOP.
- STOP:
  - Sample rs at count CLKS_PER_BIT-1.
  - rs==1: append the byte at offset 8*byte_count, increment byte_count, return to IDLE.
  - rs==0: pulse frame_err, discard the byte, clear byte_count, then go to IDLE. Re-arm only after rs is seen high, so a break condition does not retrigger.
- Word completion:
  - Triggered when byte_count would reach WORD_BYTES.
  - The next clock after the stop-bit sample: word_data loads, word_valid=1, byte_count=0.
- Handshake:
  - word_valid holds, and word_data stays stable, until a cycle with word_valid && word_ready. word_valid then drops next clock.
  - Completion in the same cycle as acceptance: the new word loads and word_valid stays 1.
  - Completion while word_valid=1 and no acceptance: pulse overrun, drop the new word, keep the old word, clear byte_count.
- Timeout:
  - Active only while byte_count>0 and state is IDLE.
  - An idle counter runs and clears on any start detection.
  - At TIMEOUT_BITS*CLKS_PER_BIT clocks: pulse timeout and clear byte_count.
- Counter widths:
  - $clog2 of the maximum value.
  - No wrap is reachable under legal parameters.
- Reset mid-frame: an immediate return to reset values; the partial word is lost.

Optional Feature:
- Macro UART_PARITY_EN.
- When defined:
  - Frame is 8E1: state PARITY sits between DATA and STOP.
  - The parity bit is sampled and checked for even parity over the data bits and the parity bit.
  - On mismatch, the byte is discarded and byte_count cleared. frame_err pulses at the stop-bit sample, i.e. the same pulse that a framing error produces.
- When undefined:
  - 8N1; no PARITY state and no parity logic.

Decomposition:
- Shared package: FSM state encoding (IDLE, START, DATA, PARITY, STOP) and the UART frame constants (DATA_BITS=8, idle level 1).
- One natural sub-module: uart_bit_sampler. It contains the synchroniser, start detection, mid-bit counter and byte shift register. It emits byte_valid, byte_data and byte_err.
- uart_word_rx keeps the assembly, handshake and timeout logic.

Test Plan:
- CLKS_PER_BIT=8, WORD_BYTES=4, word_ready=1. Send 0x78, 0x56, 0x34, 0x12 back-to-back. Expect word_data=0x12345678 with a one-cycle word_valid, one clock after the last stop-bit sample; byte_count sequence 1,2,3,0.
- Glitch on rxd: a low pulse of 3 clocks (< CLKS_PER_BIT/2). Expect false start: no byte, byte_count stays 0, busy returns to 0.
- Send 0x55 with the stop bit forced low. Expect a frame_err pulse and byte_count=0. The next clean 4-byte word 0xDEADBEEF (bytes EF, BE, AD, DE) is received correctly.
- word_ready=0. Send two full words, 0x11111111 then 0x22222222. Expect an overrun pulse and word_data still 0x11111111. Raise word_ready and expect word_valid to drop next clock.
- Send 2 bytes, then idle for 20*8 clocks. Expect a timeout pulse and byte_count 2->0. The next 4 bytes form a fresh word.
- Assert reset (0) during the DATA state of byte 3. Expect all outputs back at reset values and the partial word lost. With UART_PARITY_EN, send 0x01 with a wrong parity bit and expect a frame_err pulse with no byte accepted.
